sram_axi_arbiter: RTL and testbench
===================================

Name: sram_axi_arbiter

Overview:
- Shares one AXI3 master port between the fetch-stage instruction SRAM-like port and the memory-stage data SRAM-like port.
- Converts each port's req/addr_ok/data_ok handshake into AXI AR/R and AW/W/B transactions.
- Arbitrates reads between the two ports and keeps each port's responses in order.
- Echoes the accepted instruction address so the fetch stage can discard stale addr_ok pulses.

Parameters:
INST_ID, 4'd0, arid used for instruction reads
DATA_ID, 4'd1, arid/awid used for data accesses

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  instruction request; held with stable fields until inst_addr_ok
inst_wr  in  1  must be 0; write requests on this port are never accepted
inst_size  in  2  0=byte 1=half 2=word
inst_addr  in  32  physical address
inst_addr_ok  out  1  request accepted (1-cycle pulse)
inst_addr_ok_addr  out  32  address of the request accepted this cycle
inst_data_ok  out  1  read data valid (1-cycle pulse)
inst_rdata  out  32  read data
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1=write
data_size  in  2  access size
data_wstrb  in  4  byte enables
data_addr  in  32  physical address
data_wdata  in  32  write data
data_addr_ok  out  1  accepted pulse
data_data_ok  out  1  read data / write completion pulse
data_rdata  out  32  read data
arid,araddr,arsize,arvalid  out  4,32,3,1  AXI read address
arready  in  1
rid,rdata,rvalid  in  4,32,1  AXI read data (rresp/rlast ignored)
rready  out  1
awid,awaddr,awsize,awvalid  out  4,32,3,1  AXI write address
awready  in  1
wdata,wstrb,wvalid,wlast  out  32,4,1,1  AXI write data
wready  in  1
bvalid  in  1
bready  out  1
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot, wid  out  consts  0, 2'b01, 0, 0, 0, DATA_ID

Behaviour:
- Reset: all valid/ready outputs 0; every ok pulse 0; both FSMs idle; all latched fields 0.
- Read FSM (RD_IDLE, RD_AR, RD_R); one read outstanding in total.
  - RD_IDLE: pick a source in this priority order:
    - data read, only if data_req && !data_wr && write FSM idle;
    - else inst read, if inst_req && !inst_wr.
  - On pick: latch id/addr/size, with arsize = {1'b0,size}; go to RD_AR.
  - RD_AR: arvalid=1. On arready, go to RD_R and pulse the owner's addr_ok in that same cycle.
  - When the owner is inst, inst_addr_ok_addr = the latched araddr in that same cycle.
  - RD_R: rready=1. On rvalid with rid equal to the latched id:
    - pulse the matching data_ok;
    - drive rdata on the matching *_rdata in that cycle;
    - return to RD_IDLE.
  - Minimum latency: accept→addr_ok 1 cycle after pick; data_ok in the rvalid cycle.
- Write FSM (WR_IDLE, WR_REQ, WR_B).
  - WR_IDLE: accept data_req && data_wr only if the read FSM is not serving data (no data read in RD_AR/RD_R). This keeps data-port responses in order.
  - On accept: latch addr/size/wstrb/wdata; awvalid=wvalid=1.
  - WR_REQ: awvalid and wvalid drop independently on their handshakes.
  - When both handshakes are done (same or different cycles), pulse data_addr_ok and go to WR_B.
  - WR_B: bready=1. On bvalid, pulse data_data_ok and return to WR_IDLE.
- Simultaneous events:
  - A data read and a data write are never both pending; the write FSM wins only if the read FSM is idle or serving inst.
  - An inst read may overlap an outstanding write.
  - A data read is blocked while the write FSM is not idle (read-after-write safety).
- The data port never has more than one outstanding transaction. The inst port likewise.
- Every ok pulse is exactly one cycle and never repeats for the same request.
- rid mismatch in RD_R: ignored, no pulse.
- Reset mid-transaction: all state is abandoned; the AXI slave is reset in the same cycle.

Test Plan:
- inst read 0x1FC00000, arready same cycle, rvalid 3 cycles later with 0x3C080001 → inst_addr_ok with addr_ok_addr=0x1FC00000, then inst_data_ok with inst_rdata=0x3C080001; arid=0, arsize=2.
- inst and data reads requested in the same cycle → data is issued first (arid=1); inst is issued only after data_data_ok.
- data write 0x80001000, wstrb=4'b0011, awready 2 cycles before wready → data_addr_ok in the wready cycle; a data read to the same address is blocked until bvalid, then issues.
- write outstanding, then an inst read → AR issues while in WR_B; both complete; data_data_ok only on bvalid.
- reset asserted in RD_R → arvalid/rready/ok pulses 0 next cycle; a stray rvalid afterwards produces no data_ok.
- inst_req with inst_wr=1 → no AXI activity and no inst_addr_ok for 10 cycles.

Source files
------------

// File: rtl/sram_axi_arbiter_if.sv
// AXI3 master bus between the SRAM-to-AXI arbiter and the AXI slave.
// master: arbiter side (drives AR/AW/W, rready, bready); slave: memory side.
interface sram_axi_arbiter_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      output arvalid, rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      output awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rvalid, awready, wready, bvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      input  arvalid, rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      input  awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rvalid, awready, wready, bvalid
   );
endinterface

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master port between the inst and data SRAM-like ports.
// Ports: clk/reset, inst_* and data_* SRAM handshakes, axi (AXI3 master).
module sram_axi_arbiter #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic [31:0] inst_addr_ok_addr,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   sram_axi_arbiter_if.master axi
);

   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_B} wr_state_e;

   rd_state_e   rd_state_q, rd_state_d;
   logic        rd_is_data_q, rd_is_data_d;
   logic [3:0]  rd_id_q, rd_id_d;
   logic [31:0] araddr_q, araddr_d;
   logic [2:0]  arsize_q, arsize_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;

   wr_state_e   wr_state_q, wr_state_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [2:0]  awsize_q, awsize_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;

   logic pick_data, pick_inst;
   logic ar_fire, r_hit;
   logic rd_serving_data, wr_accept;
   logic aw_done, w_done, wr_req_done, b_fire;

   // Data reads wait for the write side to drain (read-after-write safety).
   assign pick_data = data_req & ~data_wr & (wr_state_q == WR_IDLE);
   assign pick_inst = inst_req & ~inst_wr;
   assign ar_fire   = (rd_state_q == RD_AR) & axi.arready;
   assign r_hit     = (rd_state_q == RD_R) & axi.rvalid & (axi.rid == rd_id_q);

   // A write may not start while a data read is in flight, so data-port
   // responses come back in request order.
   assign rd_serving_data = (rd_state_q != RD_IDLE) & rd_is_data_q;
   assign wr_accept = (wr_state_q == WR_IDLE) & data_req & data_wr
                    & ~rd_serving_data;

   assign aw_done     = ~awvalid_q | axi.awready;
   assign w_done      = ~wvalid_q | axi.wready;
   assign wr_req_done = (wr_state_q == WR_REQ) & aw_done & w_done;
   assign b_fire      = (wr_state_q == WR_B) & axi.bvalid;

   always_comb begin
      rd_state_d   = rd_state_q;
      rd_is_data_d = rd_is_data_q;
      rd_id_d      = rd_id_q;
      araddr_d     = araddr_q;
      arsize_d     = arsize_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (pick_data) begin
               rd_is_data_d = 1'b1;
               rd_id_d      = DATA_ID;
               araddr_d     = data_addr;
               arsize_d     = {1'b0, data_size};
               arvalid_d    = 1'b1;
               rd_state_d   = RD_AR;
            end else if (pick_inst) begin
               rd_is_data_d = 1'b0;
               rd_id_d      = INST_ID;
               araddr_d     = inst_addr;
               arsize_d     = {1'b0, inst_size};
               arvalid_d    = 1'b1;
               rd_state_d   = RD_AR;
            end
         end
         RD_AR: begin
            if (axi.arready) begin
               arvalid_d  = 1'b0;
               rready_d   = 1'b1;
               rd_state_d = RD_R;
            end
         end
         RD_R: begin
            if (r_hit) begin
               rready_d   = 1'b0;
               rd_state_d = RD_IDLE;
            end
         end
         default: begin
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            rd_state_d = RD_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      awsize_d   = awsize_q;
      wstrb_d    = wstrb_q;
      wdata_d    = wdata_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      unique case (wr_state_q)
         WR_IDLE: begin
            if (wr_accept) begin
               awaddr_d   = data_addr;
               awsize_d   = {1'b0, data_size};
               wstrb_d    = data_wstrb;
               wdata_d    = data_wdata;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               wr_state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently, in any order.
            awvalid_d = awvalid_q & ~axi.awready;
            wvalid_d  = wvalid_q & ~axi.wready;
            if (aw_done && w_done) begin
               bready_d   = 1'b1;
               wr_state_d = WR_B;
            end
         end
         WR_B: begin
            if (axi.bvalid) begin
               bready_d   = 1'b0;
               wr_state_d = WR_IDLE;
            end
         end
         default: begin
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            wr_state_d = WR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state_q   <= RD_IDLE;
         rd_is_data_q <= 1'b0;
         rd_id_q      <= 4'd0;
         araddr_q     <= 32'd0;
         arsize_q     <= 3'd0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         wr_state_q   <= WR_IDLE;
         awaddr_q     <= 32'd0;
         awsize_q     <= 3'd0;
         wstrb_q      <= 4'd0;
         wdata_q      <= 32'd0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
      end else begin
         rd_state_q   <= rd_state_d;
         rd_is_data_q <= rd_is_data_d;
         rd_id_q      <= rd_id_d;
         araddr_q     <= araddr_d;
         arsize_q     <= arsize_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         wr_state_q   <= wr_state_d;
         awaddr_q     <= awaddr_d;
         awsize_q     <= awsize_d;
         wstrb_q      <= wstrb_d;
         wdata_q      <= wdata_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
      end
   end

   // Pulses are masked during reset so abandoned transfers never complete.
   assign inst_addr_ok      = ~reset & ar_fire & ~rd_is_data_q;
   assign inst_addr_ok_addr = araddr_q;
   assign inst_data_ok      = ~reset & r_hit & ~rd_is_data_q;
   assign inst_rdata        = axi.rdata;
   assign data_addr_ok      = ~reset & ((ar_fire & rd_is_data_q) | wr_req_done);
   assign data_data_ok      = ~reset & ((r_hit & rd_is_data_q) | b_fire);
   assign data_rdata        = axi.rdata;

   assign axi.arid    = rd_id_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = arsize_q;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'd0;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign axi.awid    = DATA_ID;
   assign axi.awaddr  = awaddr_q;
   assign axi.awlen   = 4'd0;
   assign axi.awsize  = awsize_q;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'd0;
   assign axi.awcache = 4'd0;
   assign axi.awprot  = 3'd0;
   assign axi.awvalid = awvalid_q;
   assign axi.wid     = DATA_ID;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter; the bench plays the AXI slave.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_sram_axi_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0;
   logic        inst_wr = 1'b0;
   logic [1:0]  inst_size = 2'd0;
   logic [31:0] inst_addr = 32'd0;
   logic        inst_addr_ok;
   logic [31:0] inst_addr_ok_addr;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [1:0]  data_size = 2'd0;
   logic [3:0]  data_wstrb = 4'd0;
   logic [31:0] data_addr = 32'd0;
   logic [31:0] data_wdata = 32'd0;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int passed = 0;
   int total = 0;

   sram_axi_arbiter_if bus ();

   sram_axi_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .inst_req          (inst_req),
      .inst_wr           (inst_wr),
      .inst_size         (inst_size),
      .inst_addr         (inst_addr),
      .inst_addr_ok      (inst_addr_ok),
      .inst_addr_ok_addr (inst_addr_ok_addr),
      .inst_data_ok      (inst_data_ok),
      .inst_rdata        (inst_rdata),
      .data_req          (data_req),
      .data_wr           (data_wr),
      .data_size         (data_size),
      .data_wstrb        (data_wstrb),
      .data_addr         (data_addr),
      .data_wdata        (data_wdata),
      .data_addr_ok      (data_addr_ok),
      .data_data_ok      (data_data_ok),
      .data_rdata        (data_rdata),
      .axi               (bus)
   );

   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic slave_idle();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rid     = 4'd0;
      bus.rdata   = 32'd0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      slave_idle();
      repeat (2) nxt();
      reset = 1'b0;
      mid();
      total++;
      if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0)
         $display("FAIL reset_valids got=%b exp=00000",
            {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
      else passed++;
      total++;
      if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0)
         $display("FAIL reset_pulses got=%b exp=0000",
            {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
      else passed++;
      total++;
      if ({bus.arlen, bus.arburst, bus.awburst, bus.wid, bus.awid, bus.wlast}
          !== {4'd0, 2'b01, 2'b01, 4'd1, 4'd1, 1'b1})
         $display("FAIL axi_consts got=%h", {bus.arlen, bus.arburst, bus.wid});
      else passed++;
   endtask

   task automatic test_inst_read();
      nxt();
      inst_req = 1'b1; inst_addr = 32'h1FC00000; inst_size = 2'd2;
      bus.arready = 1'b1;
      mid();
      total++;
      if (bus.arvalid !== 1'b0)
         $display("FAIL ir_pick_arvalid got=%b exp=0", bus.arvalid);
      else passed++;
      nxt();
      mid();
      total++;
      if ({bus.arvalid, bus.arid, bus.arsize} !== {1'b1, 4'd0, 3'd2})
         $display("FAIL ir_ar got=%b/%h/%h exp=1/0/2",
            bus.arvalid, bus.arid, bus.arsize);
      else passed++;
      total++;
      if (bus.araddr !== 32'h1FC00000)
         $display("FAIL ir_araddr got=%h exp=1fc00000", bus.araddr);
      else passed++;
      total++;
      if ({inst_addr_ok, data_addr_ok} !== 2'b10)
         $display("FAIL ir_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok});
      else passed++;
      total++;
      if (inst_addr_ok_addr !== 32'h1FC00000)
         $display("FAIL ir_ok_addr got=%h exp=1fc00000", inst_addr_ok_addr);
      else passed++;
      nxt();
      inst_req = 1'b0; bus.arready = 1'b0;
      mid();
      total++;
      if ({bus.arvalid, bus.rready, inst_addr_ok} !== 3'b010)
         $display("FAIL ir_wait got=%b exp=010",
            {bus.arvalid, bus.rready, inst_addr_ok});
      else passed++;
      nxt();
      mid();
      total++;
      if (inst_data_ok !== 1'b0)
         $display("FAIL ir_early_data_ok got=%b exp=0", inst_data_ok);
      else passed++;
      nxt();
      bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h3C080001;
      mid();
      total++;
      if ({inst_data_ok, data_data_ok} !== 2'b10)
         $display("FAIL ir_data_ok got=%b exp=10", {inst_data_ok, data_data_ok});
      else passed++;
      total++;
      if (inst_rdata !== 32'h3C080001)
         $display("FAIL ir_rdata got=%h exp=3c080001", inst_rdata);
      else passed++;
      nxt();
      slave_idle();
      mid();
      total++;
      if ({bus.rready, inst_data_ok} !== 2'b00)
         $display("FAIL ir_done got=%b exp=00", {bus.rready, inst_data_ok});
      else passed++;
   endtask

   task automatic test_priority();
      nxt();
      inst_req = 1'b1; inst_addr = 32'h1FC00004; inst_size = 2'd2;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000010;
      data_size = 2'd2; bus.arready = 1'b1;
      nxt();
      mid();
      total++;
      if ({bus.arid, bus.araddr} !== {4'd1, 32'h80000010})
         $display("FAIL pri_data_first got=%h/%h exp=1/80000010",
            bus.arid, bus.araddr);
      else passed++;
      total++;
      if ({data_addr_ok, inst_addr_ok} !== 2'b10)
         $display("FAIL pri_addr_ok got=%b exp=10", {data_addr_ok, inst_addr_ok});
      else passed++;
      nxt();
      data_req = 1'b0;
      mid();
      total++;
      if (bus.arvalid !== 1'b0)
         $display("FAIL pri_inst_held got=%b exp=0", bus.arvalid);
      else passed++;
      nxt();
      bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hDEADBEEF;
      mid();
      total++;
      if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'hDEADBEEF})
         $display("FAIL pri_data_resp got=%b/%b/%h exp=1/0/deadbeef",
            data_data_ok, inst_data_ok, data_rdata);
      else passed++;
      nxt();
      bus.rvalid = 1'b0;
      nxt();
      mid();
      total++;
      if ({bus.arvalid, bus.arid, bus.araddr, inst_addr_ok}
          !== {1'b1, 4'd0, 32'h1FC00004, 1'b1})
         $display("FAIL pri_inst_issue got=%b/%h/%h/%b exp=1/0/1fc00004/1",
            bus.arvalid, bus.arid, bus.araddr, inst_addr_ok);
      else passed++;
      nxt();
      inst_req = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h99999999;
      mid();
      total++;
      if ({inst_data_ok, data_data_ok} !== 2'b00)
         $display("FAIL pri_rid_mismatch got=%b exp=00",
            {inst_data_ok, data_data_ok});
      else passed++;
      nxt();
      bus.rid = 4'd0; bus.rdata = 32'h11112222;
      mid();
      total++;
      if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h11112222})
         $display("FAIL pri_inst_resp got=%b/%h exp=1/11112222",
            inst_data_ok, inst_rdata);
      else passed++;
      nxt();
      slave_idle();
   endtask

   task automatic test_write_raw();
      nxt();
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80001000;
      data_size = 2'd1; data_wstrb = 4'b0011; data_wdata = 32'h0000A5A5;
      nxt();
      bus.awready = 1'b1;
      mid();
      total++;
      if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.awsize, bus.wstrb}
          !== {2'b11, 32'h80001000, 3'd1, 4'b0011})
         $display("FAIL wr_aw_w got=%b%b/%h/%h/%b exp=11/80001000/1/0011",
            bus.awvalid, bus.wvalid, bus.awaddr, bus.awsize, bus.wstrb);
      else passed++;
      total++;
      if ({bus.wdata, data_addr_ok} !== {32'h0000A5A5, 1'b0})
         $display("FAIL wr_wdata got=%h/%b exp=0000a5a5/0",
            bus.wdata, data_addr_ok);
      else passed++;
      nxt();
      bus.awready = 1'b0;
      mid();
      total++;
      if ({bus.awvalid, bus.wvalid, data_addr_ok} !== 3'b010)
         $display("FAIL wr_aw_only got=%b exp=010",
            {bus.awvalid, bus.wvalid, data_addr_ok});
      else passed++;
      nxt();
      bus.wready = 1'b1;
      mid();
      total++;
      if (data_addr_ok !== 1'b1)
         $display("FAIL wr_addr_ok got=%b exp=1", data_addr_ok);
      else passed++;
      nxt();
      bus.wready = 1'b0; data_wr = 1'b0;
      mid();
      total++;
      if ({bus.bready, bus.arvalid, data_addr_ok} !== 3'b100)
         $display("FAIL wr_raw_block got=%b exp=100",
            {bus.bready, bus.arvalid, data_addr_ok});
      else passed++;
      nxt();
      mid();
      total++;
      if (bus.arvalid !== 1'b0)
         $display("FAIL wr_raw_block2 got=%b exp=0", bus.arvalid);
      else passed++;
      nxt();
      bus.bvalid = 1'b1;
      mid();
      total++;
      if (data_data_ok !== 1'b1)
         $display("FAIL wr_b_ok got=%b exp=1", data_data_ok);
      else passed++;
      nxt();
      bus.bvalid = 1'b0; bus.arready = 1'b1;
      mid();
      total++;
      if ({data_data_ok, bus.bready} !== 2'b00)
         $display("FAIL wr_b_once got=%b exp=00", {data_data_ok, bus.bready});
      else passed++;
      nxt();
      mid();
      total++;
      if ({bus.arvalid, bus.arid, bus.araddr, data_addr_ok}
          !== {1'b1, 4'd1, 32'h80001000, 1'b1})
         $display("FAIL wr_raw_issue got=%b/%h/%h/%b exp=1/1/80001000/1",
            bus.arvalid, bus.arid, bus.araddr, data_addr_ok);
      else passed++;
      nxt();
      data_req = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h12345678;
      mid();
      total++;
      if ({data_data_ok, data_rdata} !== {1'b1, 32'h12345678})
         $display("FAIL wr_raw_resp got=%b/%h exp=1/12345678",
            data_data_ok, data_rdata);
      else passed++;
      nxt();
      slave_idle();
   endtask

   task automatic test_overlap();
      nxt();
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80002000;
      data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'h55AA55AA;
      bus.awready = 1'b1; bus.wready = 1'b1;
      nxt();
      mid();
      total++;
      if (data_addr_ok !== 1'b1)
         $display("FAIL ov_wr_addr_ok got=%b exp=1", data_addr_ok);
      else passed++;
      nxt();
      data_req = 1'b0; data_wr = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1FC00100; inst_size = 2'd2;
      bus.arready = 1'b1;
      nxt();
      mid();
      total++;
      if ({bus.arvalid, bus.arid, inst_addr_ok, bus.bready, data_data_ok}
          !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0})
         $display("FAIL ov_inst_ar got=%b/%h/%b/%b/%b exp=1/0/1/1/0",
            bus.arvalid, bus.arid, inst_addr_ok, bus.bready, data_data_ok);
      else passed++;
      nxt();
      inst_req = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hCAFE0001;
      mid();
      total++;
      if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'hCAFE0001})
         $display("FAIL ov_inst_resp got=%b/%b/%h exp=1/0/cafe0001",
            inst_data_ok, data_data_ok, inst_rdata);
      else passed++;
      nxt();
      bus.rvalid = 1'b0; bus.bvalid = 1'b1;
      mid();
      total++;
      if ({data_data_ok, inst_data_ok} !== 2'b10)
         $display("FAIL ov_b_resp got=%b exp=10", {data_data_ok, inst_data_ok});
      else passed++;
      nxt();
      slave_idle();
      mid();
      total++;
      if ({bus.bready, data_data_ok} !== 2'b00)
         $display("FAIL ov_done got=%b exp=00", {bus.bready, data_data_ok});
      else passed++;
   endtask

   task automatic test_reset_mid();
      nxt();
      inst_req = 1'b1; inst_addr = 32'h1FC00200; inst_size = 2'd2;
      bus.arready = 1'b1;
      nxt();
      mid();
      total++;
      if (inst_addr_ok !== 1'b1)
         $display("FAIL rm_addr_ok got=%b exp=1", inst_addr_ok);
      else passed++;
      nxt();
      inst_req = 1'b0; bus.arready = 1'b0; reset = 1'b1;
      nxt();
      reset = 1'b0;
      bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h77777777;
      mid();
      total++;
      if ({bus.arvalid, bus.rready} !== 2'b00)
         $display("FAIL rm_valids got=%b exp=00", {bus.arvalid, bus.rready});
      else passed++;
      total++;
      if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b000)
         $display("FAIL rm_stray_r got=%b exp=000",
            {inst_data_ok, data_data_ok, inst_addr_ok});
      else passed++;
      nxt();
      slave_idle();
   endtask

   task automatic test_inst_wr();
      nxt();
      inst_req = 1'b1; inst_wr = 1'b1; inst_addr = 32'h1FC00300;
      bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mid();
         total++;
         if ({bus.arvalid, bus.awvalid, bus.wvalid, inst_addr_ok} !== 4'b0)
            $display("FAIL iwr_cycle%0d got=%b exp=0000", i,
               {bus.arvalid, bus.awvalid, bus.wvalid, inst_addr_ok});
         else passed++;
         nxt();
      end
      inst_req = 1'b0; inst_wr = 1'b0;
      slave_idle();
   endtask

   initial begin
      slave_idle();
      test_reset();
      test_inst_read();
      test_priority();
      test_write_raw();
      test_overlap();
      test_reset_mid();
      test_inst_wr();
      nxt();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
